// File: rtl/fpmul_param_seq.sv
`timescale 1ns/1ps
// fpmul_param_seq: sequential IEEE-754 style multiplier with parametrised format.
// One operation in flight; operands accepted in IDLE, result held in DONE until taken.
// Special operands (NaN/Inf/zero, denormals as zero) bypass the arithmetic states.
module fpmul_param_seq #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  input  logic [1:0]             rnd_mode,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   p,
  output logic [3:0]             flags
);
  localparam int W    = 1 + EXP_W + MAN_W;
  localparam int SW   = MAN_W + 1;
  localparam int PW   = 2 * SW;
  localparam int XW   = EXP_W + 2;
  localparam int BIAS = (1 << (EXP_W - 1)) - 1;

  localparam logic signed [XW-1:0] BIAS_X  = XW'(BIAS);
  localparam logic signed [XW-1:0] ONE_X   = XW'(1);
  localparam logic signed [XW-1:0] ZERO_X  = '0;
  localparam logic signed [XW-1:0] EXP_MAX = XW'((1 << EXP_W) - 1);
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, CLASS, MUL, NORM, ROUND, DONE} state_t;

  state_t state, state_nx;

  // Classify the operand pair; returns {hit, result, flags}. Denormals read as zero.
  function automatic logic [W+4:0] special_pack(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [EXP_W-1:0] ex, ey;
    logic [MAN_W-1:0] mx, my;
    logic x_nan, y_nan, x_inf, y_inf, x_zero, y_zero, snan, inf_zero, sgn, hit;
    logic [W-1:0] res;
    logic [3:0]   fl;
    ex = x[W-2 -: EXP_W];  mx = x[MAN_W-1:0];
    ey = y[W-2 -: EXP_W];  my = y[MAN_W-1:0];
    x_nan  = (&ex) &  (|mx);
    y_nan  = (&ey) &  (|my);
    x_inf  = (&ex) & ~(|mx);
    y_inf  = (&ey) & ~(|my);
    x_zero = ~(|ex);
    y_zero = ~(|ey);
    snan     = (x_nan & ~mx[MAN_W-1]) | (y_nan & ~my[MAN_W-1]);
    inf_zero = (x_inf & y_zero) | (y_inf & x_zero);
    sgn = x[W-1] ^ y[W-1];
    res = '0;
    fl  = '0;
    hit = 1'b1;
    if (x_nan | y_nan | inf_zero) begin
      res = QNAN;
      fl  = {snan | inf_zero, 3'b000};
    end else if (x_inf | y_inf) begin
      res = {sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (x_zero | y_zero) begin
      res = {sgn, {(W-1){1'b0}}};
    end else begin
      hit = 1'b0;
    end
    return {hit, res, fl};
  endfunction

  // Round, handle carry-out, then resolve overflow/underflow; returns {result, flags}.
  function automatic logic [W+3:0] round_pack(input logic sgn, input logic [SW-1:0] sig,
                                              input logic g, input logic s,
                                              input logic signed [XW-1:0] ex,
                                              input logic [1:0] mode);
    logic inc, inexact;
    logic [SW:0] sum;
    logic [MAN_W-1:0] man_r;
    logic signed [XW-1:0] ex_r;
    logic [W-1:0] inf_v, max_v, res;
    logic [3:0] fl;
    inexact = g | s;
    unique case (mode)
      2'd0:    inc = g & (sig[0] | s);
      2'd1:    inc = 1'b0;
      2'd2:    inc = inexact & ~sgn;
      default: inc = inexact & sgn;
    endcase
    sum = {1'b0, sig} + {{SW{1'b0}}, inc};
    if (sum[SW]) begin
      man_r = sum[MAN_W:1];
      ex_r  = ex + ONE_X;
    end else begin
      man_r = sum[MAN_W-1:0];
      ex_r  = ex;
    end
    inf_v = {sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    max_v = {sgn, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
    if (ex_r >= EXP_MAX) begin
      fl = 4'b0101;
      unique case (mode)
        2'd0:    res = inf_v;
        2'd1:    res = max_v;
        2'd2:    res = sgn ? max_v : inf_v;
        default: res = sgn ? inf_v : max_v;
      endcase
    end else if (ex_r <= ZERO_X) begin
      fl  = 4'b0011;
      res = {sgn, {(W-1){1'b0}}};
    end else begin
      fl  = {3'b000, inexact};
      res = {sgn, ex_r[EXP_W-1:0], man_r};
    end
    return {res, fl};
  endfunction

  logic                 accept;
  logic [W-1:0]         a_p0, b_p0;
  logic [1:0]           mode_p0;
  logic [PW-1:0]        prod_p1;
  logic signed [XW-1:0] exp_p1;
  logic [PW-1:0]        norm_sh;
  logic [SW-1:0]        sig_p2;
  logic                 g_p2, s_p2;
  logic signed [XW-1:0] exp_p2;
  logic                 spec_hit;
  logic [W-1:0]         spec_res, rnd_res;
  logic [3:0]           spec_fl, rnd_fl;

  assign accept = in_valid & in_ready;
  assign {spec_hit, spec_res, spec_fl} = special_pack(a_p0, b_p0);
  assign norm_sh = prod_p1[PW-1] ? prod_p1 : {prod_p1[PW-2:0], 1'b0};
  assign {rnd_res, rnd_fl} = round_pack(a_p0[W-1] ^ b_p0[W-1], sig_p2, g_p2, s_p2, exp_p2, mode_p0);

  // State register; reset abandons any operation in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = rst_n;
        if (in_valid) state_nx = CLASS;
      end
      CLASS:   state_nx = spec_hit ? DONE : MUL;
      MUL:     state_nx = NORM;
      NORM:    state_nx = ROUND;
      ROUND:   state_nx = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // p0: operand capture at accept; held stable for the whole operation.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_p0    <= a;
      b_p0    <= b;
      mode_p0 <= rnd_mode;
    end
  end

  // p1: full significand product and signed biased exponent sum.
  always_ff @(posedge clk) begin
    if (state == MUL) begin
      prod_p1 <= PW'({1'b1, a_p0[MAN_W-1:0]}) * PW'({1'b1, b_p0[MAN_W-1:0]});
      exp_p1  <= $signed({2'b00, a_p0[W-2 -: EXP_W]}) + $signed({2'b00, b_p0[W-2 -: EXP_W]}) - BIAS_X;
    end
  end

  // p2: normalise to a leading one, extract guard and sticky.
  always_ff @(posedge clk) begin
    if (state == NORM) begin
      sig_p2 <= norm_sh[PW-1 -: SW];
      g_p2   <= norm_sh[MAN_W];
      s_p2   <= |norm_sh[MAN_W-1:0];
      exp_p2 <= prod_p1[PW-1] ? exp_p1 + ONE_X : exp_p1;
    end
  end

  // Result registers: loaded on entry to DONE, cleared by reset, held while waiting.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      p     <= '0;
      flags <= '0;
    end else if (state == CLASS && spec_hit) begin
      p     <= spec_res;
      flags <= spec_fl;
    end else if (state == ROUND) begin
      p     <= rnd_res;
      flags <= rnd_fl;
    end
  end

endmodule

// File: tb/tb_fpmul_param_seq.sv
`timescale 1ns/1ps
// Directed bench for fpmul_param_seq: single and half precision instances.
module tb_fpmul_param_seq;
  logic        clk;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] a, b, p;
  logic [1:0]  rnd_mode;
  logic [3:0]  flags;
  logic        h_in_valid, h_in_ready, h_out_valid, h_out_ready;
  logic [15:0] ha, hb, hp;
  logic [1:0]  h_rnd;
  logic [3:0]  hflags;

  typedef struct packed {
    logic [31:0] p;
    logic [3:0]  f;
    logic [31:0] lat;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  fpmul_param_seq #(.EXP_W(8), .MAN_W(23)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .rnd_mode(rnd_mode), .out_valid(out_valid),
    .out_ready(out_ready), .p(p), .flags(flags)
  );

  fpmul_param_seq #(.EXP_W(5), .MAN_W(10)) dut_h (
    .clk(clk), .rst_n(rst_n), .in_valid(h_in_valid), .in_ready(h_in_ready),
    .a(ha), .b(hb), .rnd_mode(h_rnd), .out_valid(h_out_valid),
    .out_ready(h_out_ready), .p(hp), .flags(hflags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Drive one operation, push its expectation at the accept edge, pop and check on out_valid.
  task automatic run_op(input string tag, input bit half, input logic [31:0] ta,
                        input logic [31:0] tb2, input logic [1:0] m,
                        input logic [31:0] ep, input logic [3:0] ef,
                        input int lat, input bit rel);
    exp_t e;
    int   n;
    @(negedge clk);
    if (half) begin
      ha = ta[15:0]; hb = tb2[15:0]; h_rnd = m; h_in_valid = 1'b1; h_out_ready = rel;
    end else begin
      a = ta; b = tb2; rnd_mode = m; in_valid = 1'b1; out_ready = rel;
    end
    n = 0;
    while (!(half ? h_in_ready : in_ready) && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    e.p = ep; e.f = ef; e.lat = 32'(lat);
    sb.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
    h_in_valid = 1'b0;
    n = 1;
    while (!(half ? h_out_valid : out_valid) && n < 30) begin
      @(negedge clk);
      n++;
    end
    e = sb.pop_front();
    chk({tag, "/latency"}, 32'(n), e.lat);
    chk({tag, "/p"}, half ? {16'h0, hp} : p, e.p);
    chk({tag, "/flags"}, {28'h0, half ? hflags : flags}, {28'h0, e.f});
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; rnd_mode = '0;
    h_in_valid = 1'b0; h_out_ready = 1'b0; ha = '0; hb = '0; h_rnd = '0;
    repeat (3) @(negedge clk);
    chk("reset/out_valid", {31'h0, out_valid}, 32'h0);
    chk("reset/p", p, 32'h0);
    chk("reset/flags", {28'h0, flags}, 32'h0);
    chk("reset/in_ready", {31'h0, in_ready}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle/in_ready", {31'h0, in_ready}, 32'h1);

    run_op("mul_1p5x2",   0, 32'h3FC00000, 32'h40000000, 2'd0, 32'h40400000, 4'b0000, 5, 1);
    run_op("inf_x_zero",  0, 32'h7F800000, 32'h00000000, 2'd0, 32'h7FC00000, 4'b1000, 2, 1);
    run_op("snan",        0, 32'h7FA00000, 32'h3F800000, 2'd0, 32'h7FC00000, 4'b1000, 2, 1);
    run_op("ovf_rne",     0, 32'h7F000000, 32'h40000000, 2'd0, 32'h7F800000, 4'b0101, 5, 1);
    run_op("ovf_rtz",     0, 32'h7F000000, 32'h40000000, 2'd1, 32'h7F7FFFFF, 4'b0101, 5, 1);
    run_op("ovf_neg_rup", 0, 32'hFF000000, 32'h40000000, 2'd2, 32'hFF7FFFFF, 4'b0101, 5, 1);
    run_op("ovf_pos_rup", 0, 32'h7F000000, 32'h40000000, 2'd2, 32'h7F800000, 4'b0101, 5, 1);
    run_op("ovf_pos_rdn", 0, 32'h7F000000, 32'h40000000, 2'd3, 32'h7F7FFFFF, 4'b0101, 5, 1);
    run_op("underflow",   0, 32'h00800000, 32'h3F000000, 2'd0, 32'h00000000, 4'b0011, 5, 1);
    run_op("nx_rne",      0, 32'h3F800001, 32'h3F800001, 2'd0, 32'h3F800002, 4'b0001, 5, 1);
    run_op("nx_rup",      0, 32'h3F800001, 32'h3F800001, 2'd2, 32'h3F800003, 4'b0001, 5, 1);
    run_op("nx_rtz",      0, 32'h3F800001, 32'h3F800001, 2'd1, 32'h3F800002, 4'b0001, 5, 1);
    run_op("neg_zero",    0, 32'h80000000, 32'h40000000, 2'd0, 32'h80000000, 4'b0000, 2, 1);

    // Backpressure: result must hold and a second request must be ignored.
    run_op("hold", 0, 32'h3FC00000, 32'h40000000, 2'd0, 32'h40400000, 4'b0000, 5, 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      a = 32'h3F800000; b = 32'h3F800000; in_valid = 1'b1;
      chk("hold/p", p, 32'h40400000);
      chk("hold/flags", {28'h0, flags}, 32'h0);
      chk("hold/in_ready", {31'h0, in_ready}, 32'h0);
      chk("hold/out_valid", {31'h0, out_valid}, 32'h1);
    end
    @(negedge clk);
    out_ready = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("release/out_valid", {31'h0, out_valid}, 32'h0);
    chk("release/in_ready", {31'h0, in_ready}, 32'h1);
    repeat (3) @(negedge clk);
    chk("release/no_accept", {31'h0, in_ready}, 32'h1);

    // Reset while the operation sits in MUL.
    @(negedge clk);
    a = 32'h3FC00000; b = 32'h40000000; rnd_mode = 2'd0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst/out_valid", {31'h0, out_valid}, 32'h0);
    chk("midrst/p", p, 32'h0);
    chk("midrst/in_ready", {31'h0, in_ready}, 32'h0);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("midrst/discarded", {31'h0, out_valid}, 32'h0);
    chk("midrst/idle", {31'h0, in_ready}, 32'h1);

    run_op("h_one", 1, 32'h3C00, 32'h3C00, 2'd0, 32'h3C00, 4'b0000, 5, 1);
    run_op("h_ovf", 1, 32'h7BFF, 32'h4000, 2'd0, 32'h7C00, 4'b0101, 5, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
